// File: rtl/sysmm_array.sv
// sysmm_array: weight-stationary matrix multiplier, Y = X*W for N = 1..MAX_N.
// Words arrive on one serial input: N*N W elements, then N*N X elements, both row-major.
// A MAX_N x MAX_N PE grid holds W. Each CALC cycle it multiplies one X row by W.
// The column sums of those products form one Y row. Finished Y elements are then
// streamed out row-major, one element per cycle, during DRAIN.
// Optional feature macro: SYSMM_RELU_EN. When defined, signed jobs clamp negative
// Y elements to zero.
module sysmm_array #(
    parameter int MAX_N  = 4,
    parameter int DATA_W = 16,
    localparam int OUT_W  = 2 * DATA_W + $clog2(MAX_N),
    localparam int SIZE_W = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIZE_W-1:0] in_size,
    input  logic              in_signed,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_value
);

    // CALC counts 0..2N; 2N <= 2*MAX_N must fit.
    localparam int CALC_W = $clog2(2 * MAX_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
        S_CALC,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE_W-1:0]   nm1_q, nm1_d;          // job size N-1
    logic                sgn_q, sgn_d;          // job operand signedness
    logic [SIZE_W-1:0]   row_q, row_d;          // load / drain row index
    logic [SIZE_W-1:0]   col_q, col_d;          // load / drain column index
    logic [CALC_W-1:0]   calc_cnt_q, calc_cnt_d;
    logic [DATA_W-1:0]   w_q [MAX_N][MAX_N];
    logic [DATA_W-1:0]   w_d [MAX_N][MAX_N];
    logic [DATA_W-1:0]   x_q [MAX_N][MAX_N];
    logic [DATA_W-1:0]   x_d [MAX_N][MAX_N];
    logic [OUT_W-1:0]    y_q [MAX_N][MAX_N];
    logic [OUT_W-1:0]    y_d [MAX_N][MAX_N];
    logic [OUT_W-1:0]    pe_prod_q [MAX_N][MAX_N];
    logic [OUT_W-1:0]    pe_prod_d [MAX_N][MAX_N];
    logic                prod_vld_q, prod_vld_d;
    logic [SIZE_W-1:0]   prod_row_q, prod_row_d;

    logic                accept;
    logic [SIZE_W-1:0]   size_clamped;
    logic [CALC_W-1:0]   calc_last;
    logic                feeding;
    logic [SIZE_W-1:0]   feed_row;
    logic [OUT_W-1:0]    col_sum [MAX_N];

    // Full-precision product, sign- or zero-extended to the accumulator width.
    function automatic logic [OUT_W-1:0] pe_mul(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic sgn);
        logic signed [DATA_W:0]     a_ext;
        logic signed [DATA_W:0]     b_ext;
        logic signed [2*DATA_W+1:0] p_full;
        logic [2*DATA_W-1:0]        p_trunc;
        a_ext   = {sgn & a[DATA_W-1], a};
        b_ext   = {sgn & b[DATA_W-1], b};
        p_full  = a_ext * b_ext;
        p_trunc = p_full[2*DATA_W-1:0];     // lossless in both modes
        if (sgn)
            return OUT_W'($signed(p_trunc));
        else
            return OUT_W'(p_trunc);
    endfunction

    // Result post-processing applied when a Y row is captured.
    function automatic logic [OUT_W-1:0] post_proc(input logic [OUT_W-1:0] v,
                                                   input logic sgn);
`ifdef SYSMM_RELU_EN
        if (sgn && v[OUT_W-1])
            return '0;
        else
            return v;
`else
        if (sgn)
            return v;
        else
            return v;
`endif
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD_W) || (state_q == S_LOAD_X);
    assign out_valid = (state_q == S_DRAIN);
    assign out_value = (state_q == S_DRAIN) ? y_q[row_q][col_q] : '0;

    // Control FSM: job size latch, serial load indexing, CALC timing, drain sequencing.
    always_comb begin
        state_d    = state_q;
        nm1_d      = nm1_q;
        sgn_d      = sgn_q;
        row_d      = row_q;
        col_d      = col_q;
        calc_cnt_d = calc_cnt_q;
        w_d        = w_q;
        x_d        = x_q;

        // Only matters for non-power-of-two MAX_N: sizes past the grid clamp to MAX_N.
        size_clamped = ({1'b0, in_size} > (SIZE_W + 1)'(MAX_N - 1)) ? SIZE_W'(MAX_N - 1) : in_size;
        calc_last    = CALC_W'({nm1_q, 1'b0}) + CALC_W'(2);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    nm1_d     = size_clamped;
                    sgn_d     = in_signed;
                    w_d[0][0] = in_data;
                    row_d     = '0;
                    if (size_clamped == '0) begin
                        col_d   = '0;
                        state_d = S_LOAD_X;
                    end else begin
                        col_d   = SIZE_W'(1);
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (accept) begin
                    w_d[row_q][col_q] = in_data;
                    if (col_q == nm1_q) begin
                        col_d = '0;
                        if (row_q == nm1_q) begin
                            row_d   = '0;
                            state_d = S_LOAD_X;
                        end else begin
                            row_d = row_q + SIZE_W'(1);
                        end
                    end else begin
                        col_d = col_q + SIZE_W'(1);
                    end
                end
            end
            S_LOAD_X: begin
                if (accept) begin
                    x_d[row_q][col_q] = in_data;
                    if (col_q == nm1_q) begin
                        col_d = '0;
                        if (row_q == nm1_q) begin
                            row_d      = '0;
                            calc_cnt_d = '0;
                            state_d    = S_CALC;
                        end else begin
                            row_d = row_q + SIZE_W'(1);
                        end
                    end else begin
                        col_d = col_q + SIZE_W'(1);
                    end
                end
            end
            S_CALC: begin
                // 2N+1 cycles here put the first output 2N+2 cycles after the last X word.
                calc_cnt_d = calc_cnt_q + CALC_W'(1);
                if (calc_cnt_q == calc_last) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (col_q == nm1_q) begin
                    col_d = '0;
                    if (row_q == nm1_q) begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + SIZE_W'(1);
                    end
                end else begin
                    col_d = col_q + SIZE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PE grid: PE(k,j) multiplies X[row][k] by its stationary W[k][j]; PEs outside NxN give zero.
    always_comb begin
        feeding    = (state_q == S_CALC) && (calc_cnt_q <= CALC_W'(nm1_q));
        feed_row   = calc_cnt_q[SIZE_W-1:0];
        prod_vld_d = feeding;
        prod_row_d = feed_row;
        for (int k = 0; k < MAX_N; k++) begin
            for (int j = 0; j < MAX_N; j++) begin
                pe_prod_d[k][j] = '0;
                if (feeding && (k <= int'(nm1_q)) && (j <= int'(nm1_q)))
                    pe_prod_d[k][j] = pe_mul(x_q[feed_row][k], w_q[k][j], sgn_q);
            end
        end
    end

    // Column accumulation of registered PE products; captures one Y row per cycle.
    always_comb begin
        y_d = y_q;
        for (int j = 0; j < MAX_N; j++) begin
            col_sum[j] = '0;
            for (int k = 0; k < MAX_N; k++)
                col_sum[j] = col_sum[j] + pe_prod_q[k][j];
        end
        if (prod_vld_q) begin
            for (int j = 0; j < MAX_N; j++)
                y_d[prod_row_q][j] = post_proc(col_sum[j], sgn_q);
        end
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            nm1_q      <= '0;
            sgn_q      <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            calc_cnt_q <= '0;
            prod_vld_q <= 1'b0;
            prod_row_q <= '0;
            for (int r = 0; r < MAX_N; r++) begin
                for (int c = 0; c < MAX_N; c++) begin
                    w_q[r][c]       <= '0;
                    x_q[r][c]       <= '0;
                    y_q[r][c]       <= '0;
                    pe_prod_q[r][c] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            nm1_q      <= nm1_d;
            sgn_q      <= sgn_d;
            row_q      <= row_d;
            col_q      <= col_d;
            calc_cnt_q <= calc_cnt_d;
            prod_vld_q <= prod_vld_d;
            prod_row_q <= prod_row_d;
            w_q        <= w_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pe_prod_q  <= pe_prod_d;
        end
    end

endmodule
